// File: rtl/barret_761_rr_sched.sv
// Round-robin scheduler feeding a shared 3-stage Barrett reducer (x mod 761).
// Latency: an operand accepted at edge N is held on out_r from edge N+2 and handshaken at edge N+3; one result per cycle.
// Backpressure: stall = out_valid & ~out_ready holds S3, lets S1/S2 close bubbles, and drops all req_ready.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req_valid/ready   per-requester handshake; req_ready is one-hot-or-zero
//   req_din           19-bit operands, requester i at [19*i+18 : 19*i]
//   out_valid/ready   result handshake; out_r = din mod 761, out_tag = requester index
//   done_count        completed-result counter, live only with BARRET_761_SCHED_STATS_EN, else 0
module barret_761_rr_sched #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [19*NUM_REQ-1:0] req_din,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9:0]            out_r,
  output logic [1:0]            out_tag,
  output logic [15:0]           done_count
);

  localparam int TAG_W = 2;
  localparam int DW    = 19;

  // Round-robin pointer: index with top priority this cycle.
  logic [TAG_W-1:0] ptr_q, ptr_d;

  // Pipeline state
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [DW-1:0]    din1_q, din1_d;
  logic [19:0]      qh1_q, qh1_d;
  logic [19:0]      r2_q, r2_d;
  logic [9:0]       r3_q, r3_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;

  logic             gnt_any;
  logic [TAG_W-1:0] gnt_idx;
  logic             stall, accept, fire;
  logic             en1, en2, en3;
  logic [DW-1:0]    din_sel;

  // Arbiter: scan from the pointer upward; the lowest offset with a valid request wins.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = TAG_W'(idx);
      end
    end
  end

  assign stall   = v3_q & ~out_ready;
  // Not stalled implies S3 drains, so S1 is always vacated; no grant in reset.
  assign accept  = ~stall & ~rst;
  assign fire    = gnt_any & accept;
  assign req_ready = fire ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign din_sel = req_din[int'(gnt_idx)*DW +: DW];

  // Stage enables: a stage loads when it is empty or its successor loads,
  // which lets bubbles collapse while the output is stalled.
  assign en3 = ~v3_q | out_ready;
  assign en2 = ~v2_q | en3;
  assign en1 = ~v1_q | en2;

  always_comb begin
    ptr_d  = ptr_q;
    v1_d   = v1_q;   din1_d = din1_q; qh1_d = qh1_q; tag1_d = tag1_q;
    v2_d   = v2_q;   r2_d   = r2_q;   tag2_d = tag2_q;
    v3_d   = v3_q;   r3_d   = r3_q;   tag3_d = tag3_q;

    if (fire) begin
      ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    // S1: capture operand and the quotient estimate numerator.
    if (en1) begin
      v1_d   = fire;
      din1_d = din_sel;
      qh1_d  = 20'(din_sel >> 10) * 20'd1377;
      tag1_d = gnt_idx;
    end

    // S2: partial remainder; the estimated quotient never exceeds the true one.
    if (en2) begin
      v2_d   = v1_q;
      r2_d   = {1'b0, din1_q} - ((qh1_q >> 10) * 20'd761);
      tag2_d = tag1_q;
    end

    // S3: final correction. The truncated estimate can be low by up to two,
    // so the partial remainder lies in 0..2282 and may need 761 removed twice.
    if (en3) begin
      v3_d   = v2_q;
      tag3_d = tag2_q;
      if (r2_q >= 20'd1522) begin
        r3_d = 10'(r2_q - 20'd1522);
      end else if (r2_q >= 20'd761) begin
        r3_d = 10'(r2_q - 20'd761);
      end else begin
        r3_d = 10'(r2_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      v1_q   <= 1'b0; din1_q <= '0; qh1_q <= '0; tag1_q <= '0;
      v2_q   <= 1'b0; r2_q   <= '0; tag2_q <= '0;
      v3_q   <= 1'b0; r3_q   <= '0; tag3_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      v1_q   <= v1_d;  din1_q <= din1_d; qh1_q <= qh1_d; tag1_q <= tag1_d;
      v2_q   <= v2_d;  r2_q   <= r2_d;   tag2_q <= tag2_d;
      v3_q   <= v3_d;  r3_q   <= r3_d;   tag3_q <= tag3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_r     = r3_q;
  assign out_tag   = tag3_q;

`ifdef BARRET_761_SCHED_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Free-running wrap at 65535 -> 0.
  always_comb begin
    cnt_d = cnt_q;
    if (v3_q & out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_count = cnt_q;
`else
  assign done_count = '0;
`endif

endmodule

// File: tb/tb_barret_761_rr_sched.sv
module tb_barret_761_rr_sched;

  localparam int N = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [19*N-1:0]   req_din;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [9:0]        out_r;
  logic [1:0]        out_tag;
  logic [15:0]       done_count;

  barret_761_rr_sched #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_din    (req_din),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_tag    (out_tag),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] r;
    logic [1:0] tag;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  bit   lat_chk = 0;
  bit   rec_gnt = 0;
  logic [9:0] hold_r;
  logic [1:0] hold_tag;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle between active edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_r", out_r, e.r);
          check("out_tag", out_tag, e.tag);
          if (lat_chk) check("latency", cyc - e.cyc, 3);
        end
        hs_cnt++;
`ifndef BARRET_761_SCHED_STATS_EN
        check("done_count_zero", done_count, 0);
`endif
      end
      check("ready_onehot", ($countones(req_ready) <= 1), 1);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          logic [18:0] d;
          d     = req_din[i*19 +: 19];
          e.r   = 10'(int'(d) % 761);
          e.tag = 2'(i);
          e.cyc = cyc;
          sb.push_back(e);
          if (rec_gnt) gq.push_back(i);
        end
      end
    end
  end

  task automatic rand_din();
    for (int i = 0; i < N; i++) req_din[i*19 +: 19] = 19'($urandom);
  endtask

  task automatic send0(input int d);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_din[18:0] = 19'(d);
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[0]) ok = 1;
    end
    check("send_grant", ok, 1);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic drain();
    bit empty;
    empty = (sb.size() == 0);
    for (int k = 0; k < 40 && !empty; k++) begin
      @(negedge clk);
      empty = (sb.size() == 0);
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_din = '0; out_ready = 1'b1;
    #2 req_valid = '1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_done_count", done_count, 0);
    check("rst_req_ready", req_ready, 0);
    @(negedge clk); @(negedge clk);
    req_valid = '0; rst = 1'b0;

    // Single operands and boundary values through requester 0.
    lat_chk = 1;
    send0(761); send0(760); send0(0);
    send0(524287); send0(1522); send0(100000); send0(1521);
    drain();

    // Reset with three operands in flight.
    @(posedge clk); #1;
    req_valid = 4'b0001; req_din[18:0] = 19'd5000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req_din[18:0] = 19'(5001 + k);
    end
    req_valid = '0;
    check("pre_rst_out_valid", out_valid, 1);
    #1 rst = 1'b1; req_valid = '1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_done_count", done_count, 0);
    sb.delete(); hs_cnt = 0;
    @(negedge clk);
    rst = 1'b0; req_valid = '0;

    // All requesters valid for eight grants right after reset.
    @(posedge clk); #1;
    gq.delete(); rec_gnt = 1; req_valid = '1; rand_din();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rand_din();
    end
    req_valid = '0; rec_gnt = 0;
    check("rr_grant_count", gq.size(), 8);
    for (int k = 0; k < gq.size(); k++) check("rr_grant_order", gq[k], k % 4);
    drain();
    lat_chk = 0;

    // Backpressure while streaming.
    @(posedge clk); #1;
    out_ready = 1'b1; req_valid = '1; rand_din();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      rand_din();
    end
    out_ready = 1'b0;
    @(negedge clk);
    hold_r = out_r; hold_tag = out_tag;
    check("bp_out_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      check("bp_hold_r", out_r, hold_r);
      check("bp_hold_tag", out_tag, hold_tag);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rand_din();
    end
    req_valid = '0;
    drain();

    // Random traffic with random backpressure.
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom);
      rand_din();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0; out_ready = 1'b1;
    drain();

`ifdef BARRET_761_SCHED_STATS_EN
    @(posedge clk); #2;
    rst = 1'b1;
    #1 sb.delete(); hs_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    req_valid = '1; rand_din();
    for (int k = 0; k < 70000; k++) begin
      @(posedge clk); #1;
      rand_din();
    end
    req_valid = '0;
    drain();
    @(negedge clk);
    check("stats_handshakes", hs_cnt, 70000);
    check("stats_done_count", done_count, 32'(hs_cnt % 65536));
`else
    check("final_done_count", done_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
